// File: rtl/riscv_lsu_mem_master_pkg.sv
// Shared types and request-legality helpers for the RV32 load/store memory master.
package riscv_mem_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'd0,
      F3_H  = 3'd1,
      F3_W  = 3'd2,
      F3_BU = 3'd4,
      F3_HU = 3'd5
   } funct3_e;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      RESP
   } lsu_state_e;

   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic res;
      case (funct3)
         F3_W:        res = (off != 2'b00);
         F3_H, F3_HU: res = off[0];
         default:     res = 1'b0;
      endcase
      return res;
   endfunction

   // Stores have no unsigned variants, so BU/HU are only legal for loads.
   function automatic logic illegal_funct3(input logic we, input logic [2:0] funct3);
      logic res;
      case (funct3)
         F3_B, F3_H, F3_W: res = 1'b0;
         F3_BU, F3_HU:     res = we;
         default:          res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/riscv_lsu_mem_master_if.sv
// Request/response channels plus the single-port ap_memory port of the LSU memory master.
interface riscv_lsu_mem_master_if #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [AWIDTH-1:0] address0;
   logic              ce0;
   logic              we0;
   logic [DWIDTH-1:0] d0;
   logic [DWIDTH-1:0] q0;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, q0,
      output req_ready, resp_valid, resp_rdata, resp_err, address0, ce0, we0, d0
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, q0,
      input  req_ready, resp_valid, resp_rdata, resp_err, address0, ce0, we0, d0
   );
endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge into a read word.
module riscv_lsu_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word_in,
   input  logic [31:0] wdata,
   output logic [31:0] load_out,
   output logic [31:0] merge_out
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [3:0]  byte_en;
   logic [31:0] wdata_rep;

   always_comb begin
      lane_byte = word_in[{byte_off, 3'b000} +: 8];
      lane_half = byte_off[1] ? word_in[31:16] : word_in[15:0];
      case (funct3)
         F3_B:    load_out = {{24{lane_byte[7]}}, lane_byte};
         F3_BU:   load_out = {24'h0, lane_byte};
         F3_H:    load_out = {{16{lane_half[15]}}, lane_half};
         F3_HU:   load_out = {16'h0, lane_half};
         default: load_out = word_in;
      endcase
   end

   // Replicating store data across lanes lets each byte lane pick from one source.
   always_comb begin
      case (funct3)
         F3_B: begin
            wdata_rep = {4{wdata[7:0]}};
            byte_en   = 4'b0001 << byte_off;
         end
         F3_H: begin
            wdata_rep = {2{wdata[15:0]}};
            byte_en   = byte_off[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_rep = wdata;
            byte_en   = 4'b1111;
         end
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merge_out[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8] : word_in[8*gi +: 8];
   end

endmodule

// File: rtl/riscv_lsu_mem_master.sv
// One-at-a-time RV32 load/store engine driving a single-port word memory, with RMW for SB/SH.
module riscv_lsu_mem_master
   import riscv_mem_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int AWIDTH     = 5,
   parameter int RD_LATENCY = 1
) (
   input logic                   clk,
   input logic                   rst,
   riscv_lsu_mem_master_if.master bus
);

   localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   lsu_state_e        state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic [AWIDTH-1:0] address0_q, address0_d;
   logic              ce0_q, ce0_d;
   logic              we0_q, we0_d;
   logic [DWIDTH-1:0] d0_q, d0_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              acc_err;
   logic [31:0]       load_word;
   logic [31:0]       merge_word;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^bus.req_addr[31:AWIDTH+2];

   riscv_lsu_align u_align (
      .funct3    (funct3_q),
      .byte_off  (off_q),
      .word_in   (bus.q0),
      .wdata     (wdata_q),
      .load_out  (load_word),
      .merge_out (merge_word)
   );

   always_comb begin
      state_d      = state_q;
      req_ready_d  = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      address0_d   = address0_q;
      ce0_d        = 1'b0;
      we0_d        = 1'b0;
      d0_d         = d0_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      acc_err      = illegal_funct3(bus.req_we, bus.req_funct3) ||
                     misaligned(bus.req_funct3, bus.req_addr[1:0]);

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               we_d        = bus.req_we;
               funct3_d    = bus.req_funct3;
               off_d       = bus.req_addr[1:0];
               wdata_d     = bus.req_wdata;
               address0_d  = bus.req_addr[AWIDTH+1:2];
               if (acc_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                  state_d = WR_ISSUE;
                  ce0_d   = 1'b1;
                  we0_d   = 1'b1;
                  d0_d    = bus.req_wdata;
               end else begin
                  state_d = RD_ISSUE;
                  ce0_d   = 1'b1;
               end
            end
         end
         RD_ISSUE: begin
            state_d = RD_WAIT;
            cnt_d   = CW'(RD_LATENCY - 1);
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               if (we_q) begin
                  // Sub-word store: write back the read word with only the addressed lanes replaced.
                  state_d = WR_ISSUE;
                  ce0_d   = 1'b1;
                  we0_d   = 1'b1;
                  d0_d    = merge_word;
               end else begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
                  resp_rdata_d = load_word;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WR_ISSUE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'h0;
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
         address0_q   <= '0;
         ce0_q        <= 1'b0;
         we0_q        <= 1'b0;
         d0_q         <= '0;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         wdata_q      <= 32'h0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         address0_q   <= address0_d;
         ce0_q        <= ce0_d;
         we0_q        <= we0_d;
         d0_q         <= d0_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.address0   = address0_q;
   assign bus.ce0        = ce0_q;
   assign bus.we0        = we0_q;
   assign bus.d0         = d0_q;

endmodule

// File: tb/tb_riscv_lsu_mem_master.sv
// Drives two LSU instances (read latency 1 and 2) in lockstep against a word-array reference model.
module tb_riscv_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  rr;
   logic        load_ram;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] init_val   [32];
   logic [31:0] mem_model  [32];
   logic [31:0] ram0       [32];
   logic [31:0] ram1       [32];
   logic [31:0] pipe1;

   logic [1:0]  o_ce, o_we, o_valid, o_err, o_rreq;
   logic [4:0]  o_addr  [2];
   logic [31:0] o_d0    [2];
   logic [31:0] o_rdata [2];

   always #5 clk = ~clk;

   riscv_lsu_mem_master_if #(.AWIDTH(5), .DWIDTH(32)) b0 ();
   riscv_lsu_mem_master_if #(.AWIDTH(5), .DWIDTH(32)) b1 ();

   riscv_lsu_mem_master #(.DWIDTH(32), .AWIDTH(5), .RD_LATENCY(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
   riscv_lsu_mem_master #(.DWIDTH(32), .AWIDTH(5), .RD_LATENCY(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

   assign b0.req_valid = req_valid;  assign b1.req_valid = req_valid;
   assign b0.req_we = req_we;        assign b1.req_we = req_we;
   assign b0.req_funct3 = req_funct3; assign b1.req_funct3 = req_funct3;
   assign b0.req_addr = req_addr;    assign b1.req_addr = req_addr;
   assign b0.req_wdata = req_wdata;  assign b1.req_wdata = req_wdata;
   assign b0.resp_ready = rr[0];     assign b1.resp_ready = rr[1];

   assign o_ce    = {b1.ce0, b0.ce0};
   assign o_we    = {b1.we0, b0.we0};
   assign o_valid = {b1.resp_valid, b0.resp_valid};
   assign o_err   = {b1.resp_err, b0.resp_err};
   assign o_rreq  = {b1.req_ready, b0.req_ready};
   assign o_addr[0] = b0.address0;   assign o_addr[1] = b1.address0;
   assign o_d0[0] = b0.d0;           assign o_d0[1] = b1.d0;
   assign o_rdata[0] = b0.resp_rdata; assign o_rdata[1] = b1.resp_rdata;

   // Posedge RAMs: latency 1 for u0, an extra output stage for u1.
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < 32; i++) ram0[i] <= init_val[i];
      end else if (b0.ce0) begin
         if (b0.we0) ram0[b0.address0] <= b0.d0;
         else        b0.q0 <= ram0[b0.address0];
      end
   end

   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < 32; i++) ram1[i] <= init_val[i];
      end else if (b1.ce0) begin
         if (b1.we0) ram1[b1.address0] <= b1.d0;
         else        pipe1 <= ram1[b1.address0];
      end
      b1.q0 <= pipe1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed access on a word array using sizes, shifts and masks.
   task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata,
                        output bit [31:0] rd, output bit err, output bit [31:0] wword);
      int unsigned off, idx, size;
      bit [31:0] mask, v, old;
      off = addr[1:0];
      idx = addr[6:2];
      err = 1'b0;
      rd  = 32'h0;
      size = 4;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    err = 1'b1;
      endcase
      if (we && f3 > 3'd2) err = 1'b1;
      if ((off % size) != 0) err = 1'b1;
      old   = mem_model[idx];
      wword = old;
      mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      if (!err) begin
         if (we) begin
            wword = (old & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            mem_model[idx] = wword;
         end else begin
            v = (old >> (8 * off)) & mask;
            if (f3 < 3'd4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
            rd = v;
         end
      end
   endtask

   task automatic txn(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata,
                      input int stall);
      bit [31:0] erd, ew;
      bit        eerr;
      int        exp_lat[2], lat[2], nce[2], nwe[2], c1[2], c2[2], cnt[2];
      bit        seen[2], done[2];
      int        exp_nce, exp_nwe, cyc;
      bit        rmw;
      model(we, f3, addr, wdata, erd, eerr, ew);
      rmw = we && (f3 != 3'd2);
      for (int d = 0; d < 2; d++) begin
         exp_lat[d] = eerr ? 1 : (we && !rmw) ? 2 : rmw ? 3 + (d + 1) : 2 + (d + 1);
         nce[d] = 0; nwe[d] = 0; c1[d] = -1; c2[d] = -1; cnt[d] = 0; lat[d] = -1;
         seen[d] = 1'b0; done[d] = 1'b0;
         chk("idle_req_ready", {31'h0, o_rreq[d]}, 32'h1);
      end
      exp_nce = eerr ? 0 : rmw ? 2 : 1;
      exp_nwe = (eerr || !we) ? 0 : 1;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (!(done[0] && done[1]) && cyc < 40) begin
         for (int d = 0; d < 2; d++) begin
            if (o_ce[d]) begin
               nce[d]++;
               if (nce[d] == 1) c1[d] = cyc; else c2[d] = cyc;
               chk("address0", {27'h0, o_addr[d]}, {27'h0, addr[6:2]});
               if (o_we[d]) chk("d0", o_d0[d], ew);
            end
            if (o_we[d]) nwe[d]++;
            if (done[d]) begin
            end else if (seen[d] && rr[d]) begin
               done[d] = 1'b1;
               rr[d] = 1'b0;
               chk("valid_drop", {31'h0, o_valid[d]}, 32'h0);
            end else if (seen[d]) begin
               chk("stall_valid", {31'h0, o_valid[d]}, 32'h1);
               chk("stall_rdata", o_rdata[d], erd);
               chk("stall_err", {31'h0, o_err[d]}, {31'h0, eerr});
               chk("stall_req_ready", {31'h0, o_rreq[d]}, 32'h0);
               cnt[d]++;
               if (cnt[d] >= stall) rr[d] = 1'b1;
            end else if (o_valid[d]) begin
               seen[d] = 1'b1;
               lat[d] = cyc;
               chk("resp_latency", lat[d], exp_lat[d]);
               chk("resp_rdata", o_rdata[d], erd);
               chk("resp_err", {31'h0, o_err[d]}, {31'h0, eerr});
               chk("busy_req_ready", {31'h0, o_rreq[d]}, 32'h0);
               cnt[d] = 0;
               if (stall == 0) rr[d] = 1'b1;
            end else begin
               chk("busy_req_ready", {31'h0, o_rreq[d]}, 32'h0);
            end
         end
         if (!(done[0] && done[1])) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      rr = 2'b00;
      for (int d = 0; d < 2; d++) begin
         chk("resp_timeout", {31'h0, done[d]}, 32'h1);
         chk("ce0_count", nce[d], exp_nce);
         chk("we0_count", nwe[d], exp_nwe);
         if (exp_nce >= 1) chk("ce0_first_cycle", c1[d], 1);
         if (exp_nce == 2) chk("ce0_write_cycle", c2[d], 2 + (d + 1));
      end
      $display("txn we=%0d f3=%0d addr=%h wdata=%h exp_rdata=%h exp_err=%0d lat=%0d/%0d",
               we, f3, addr, wdata, erd, eerr, lat[0], lat[1]);
   endtask

   task automatic check_ram(input string tag);
      for (int i = 0; i < 32; i++) begin
         chk({tag, "_ram0"}, ram0[i], mem_model[i]);
         chk({tag, "_ram1"}, ram1[i], mem_model[i]);
      end
   endtask

   initial begin
      bit [31:0] a;
      rst = 1'b1; load_ram = 1'b1; rr = 2'b00;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < 32; i++) init_val[i] = $urandom;
      init_val[0] = 32'd2; init_val[1] = 32'd13; init_val[2] = 32'd24; init_val[3] = 32'd6;
      for (int i = 0; i < 32; i++) mem_model[i] = init_val[i];
      repeat (3) @(posedge clk);
      #1;
      load_ram = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", {31'h0, o_rreq[d]}, 32'h0);
         chk("rst_resp_valid", {31'h0, o_valid[d]}, 32'h0);
         chk("rst_resp_rdata", o_rdata[d], 32'h0);
         chk("rst_resp_err", {31'h0, o_err[d]}, 32'h0);
         chk("rst_ce0", {31'h0, o_ce[d]}, 32'h0);
         chk("rst_we0", {31'h0, o_we[d]}, 32'h0);
         chk("rst_address0", {27'h0, o_addr[d]}, 32'h0);
         chk("rst_d0", o_d0[d], 32'h0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) chk("post_rst_req_ready", {31'h0, o_rreq[d]}, 32'h1);

      txn(1'b0, 3'd2, 32'h4, 32'h0, 0);
      txn(1'b1, 3'd0, 32'h9, 32'h0000_00FF, 0);
      chk("sb_word", ram0[2], 32'h0000_FF18);
      txn(1'b0, 3'd0, 32'h9, 32'h0, 0);
      txn(1'b0, 3'd4, 32'h9, 32'h0, 0);
      txn(1'b0, 3'd2, 32'h8, 32'h0, 0);
      txn(1'b1, 3'd1, 32'hE, 32'h1234_ABCD, 0);
      chk("sh_word", ram1[3], 32'hABCD_0006);
      txn(1'b0, 3'd1, 32'hE, 32'h0, 0);
      txn(1'b0, 3'd5, 32'hE, 32'h0, 0);
      txn(1'b0, 3'd2, 32'h6, 32'h0, 0);
      txn(1'b0, 3'd1, 32'h3, 32'h0, 0);
      txn(1'b0, 3'd3, 32'h0, 32'h0, 0);
      txn(1'b1, 3'd4, 32'h0, 32'h1, 1);
      check_ram("err");
      txn(1'b1, 3'd2, 32'h0, 32'hDEAD_BEEF, 5);
      chk("sw_word", ram0[0], 32'hDEAD_BEEF);

      // Reset during the read phase of an SB: no write may ever reach the RAMs.
      req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h1; req_wdata = 32'h0000_0055; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_mid_we0_c1", {30'h0, o_we}, 32'h0);
      @(posedge clk); #1;
      chk("rst_mid_we0_c2", {30'h0, o_we}, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("rst_mid_ce0", {31'h0, o_ce[d]}, 32'h0);
         chk("rst_mid_we0", {31'h0, o_we[d]}, 32'h0);
         chk("rst_mid_valid", {31'h0, o_valid[d]}, 32'h0);
         chk("rst_mid_rdata", o_rdata[d], 32'h0);
         chk("rst_mid_err", {31'h0, o_err[d]}, 32'h0);
         chk("rst_mid_ready", {31'h0, o_rreq[d]}, 32'h0);
         chk("rst_mid_addr", {27'h0, o_addr[d]}, 32'h0);
         chk("rst_mid_d0", o_d0[d], 32'h0);
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_mid_we0_after", {31'h0, o_we[d]}, 32'h0);
         chk("rst_mid_ready_after", {31'h0, o_rreq[d]}, 32'h1);
      end
      check_ram("rst_mid");
      txn(1'b0, 3'd2, 32'h4, 32'h0, 0);

      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, int'($urandom_range(0, 2)));
      end
      check_ram("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
